// File: rtl/pipeline_pkg.sv
// Shared pipeline types and constants.
// Widths, ALU opcodes and the EX control bundle.
package pipeline_pkg;

   localparam int DATA_W = 16;
   localparam int REG_W  = 3;
   localparam int OP_W   = 4;
   localparam int CNT_W  = 16;

   localparam logic [OP_W-1:0] ALU_ADD = 4'h0;
   localparam logic [OP_W-1:0] ALU_SUB = 4'h1;
   localparam logic [OP_W-1:0] ALU_AND = 4'h2;
   localparam logic [OP_W-1:0] ALU_OR  = 4'h3;
   localparam logic [OP_W-1:0] ALU_XOR = 4'h4;
   localparam logic [OP_W-1:0] ALU_SLL = 4'h5;
   localparam logic [OP_W-1:0] ALU_SRL = 4'h6;
   localparam logic [OP_W-1:0] ALU_PASS = 4'h7;

   typedef struct packed {
      logic valid;
      logic wb;
      logic mem_read;
      logic mem_write;
   } ctrl_t;

   localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/load_use_detector.sv
// Flags a decoded instruction that reads the
// destination of a load still sitting in EX.
module load_use_detector #(
   parameter int REG_W = 3
) (
   input  logic             ex_valid,
   input  logic             ex_mem_read,
   input  logic             ex_wb,
   input  logic [REG_W-1:0] ex_dst,
   input  logic             id_valid,
   input  logic             id_uses_src,
   input  logic [REG_W-1:0] id_src,
   input  logic             id_uses_dst,
   input  logic [REG_W-1:0] id_dst,
   output logic             hazard
);

   logic ex_load;
   logic reads_dst;

   always_comb begin
      ex_load   = ex_valid & ex_mem_read & ex_wb;
      reads_dst = (id_uses_src & (id_src == ex_dst))
                | (id_uses_dst & (id_dst == ex_dst));
      hazard    = ex_load & id_valid & reads_dst;
   end

endmodule

// File: rtl/id_ex_stage_register.sv
// ID->EX pipeline register with load-use bubble
// insertion, memory-stall hold and branch flush.
module id_ex_stage_register #(
   parameter int DATA_W = pipeline_pkg::DATA_W,
   parameter int REG_W  = pipeline_pkg::REG_W,
   parameter int OP_W   = pipeline_pkg::OP_W,
   parameter int CNT_W  = pipeline_pkg::CNT_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic [REG_W-1:0]  id_src,
   input  logic [REG_W-1:0]  id_dst,
   input  logic              id_uses_src,
   input  logic              id_uses_dst,
   input  logic              id_wb,
   input  logic              id_mem_read,
   input  logic              id_mem_write,
   input  logic [OP_W-1:0]   id_alu_op,
   input  logic [DATA_W-1:0] id_op1,
   input  logic [DATA_W-1:0] id_op2,
   input  logic              mem_busy,
   input  logic              flush,
   output logic              ex_valid,
   output logic              ex_wb,
   output logic              ex_mem_read,
   output logic              ex_mem_write,
   output logic [REG_W-1:0]  ex_src,
   output logic [REG_W-1:0]  ex_dst,
   output logic [OP_W-1:0]   ex_alu_op,
   output logic [DATA_W-1:0] ex_op1,
   output logic [DATA_W-1:0] ex_op2,
   output logic              stall_if_id,
   output logic [CNT_W-1:0]  stall_count
);
   import pipeline_pkg::*;

   ctrl_t             ctrl_q, ctrl_d;
   logic [REG_W-1:0]  src_q, src_d;
   logic [REG_W-1:0]  dst_q, dst_d;
   logic [OP_W-1:0]   op_q, op_d;
   logic [DATA_W-1:0] op1_q, op1_d;
   logic [DATA_W-1:0] op2_q, op2_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              hazard;

   load_use_detector #(.REG_W(REG_W)) u_lud (
      .ex_valid    (ctrl_q.valid),
      .ex_mem_read (ctrl_q.mem_read),
      .ex_wb       (ctrl_q.wb),
      .ex_dst      (dst_q),
      .id_valid    (id_valid),
      .id_uses_src (id_uses_src),
      .id_src      (id_src),
      .id_uses_dst (id_uses_dst),
      .id_dst      (id_dst),
      .hazard      (hazard)
   );

   always_comb begin
      ctrl_d = ctrl_q;
      src_d  = src_q;
      dst_d  = dst_q;
      op_d   = op_q;
      op1_d  = op1_q;
      op2_d  = op2_q;
      cnt_d  = cnt_q;
      if (flush || (!mem_busy && hazard)) begin
         ctrl_d = CTRL_BUBBLE;
         src_d  = '0;
         dst_d  = '0;
         op_d   = '0;
         op1_d  = '0;
         op2_d  = '0;
         // a squashed hazard is not a bubble we paid for
         if (!flush && (cnt_q != '1))
            cnt_d = cnt_q + CNT_W'(1);
      end else if (!mem_busy) begin
         ctrl_d = CTRL_BUBBLE;
         if (id_valid)
            ctrl_d = '{valid: 1'b1, wb: id_wb,
                       mem_read: id_mem_read,
                       mem_write: id_mem_write};
         src_d  = id_src;
         dst_d  = id_dst;
         op_d   = id_alu_op;
         op1_d  = id_op1;
         op2_d  = id_op2;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ctrl_q <= CTRL_BUBBLE;
         src_q  <= '0;
         dst_q  <= '0;
         op_q   <= '0;
         op1_q  <= '0;
         op2_q  <= '0;
         cnt_q  <= '0;
      end else begin
         ctrl_q <= ctrl_d;
         src_q  <= src_d;
         dst_q  <= dst_d;
         op_q   <= op_d;
         op1_q  <= op1_d;
         op2_q  <= op2_d;
         cnt_q  <= cnt_d;
      end
   end

   always_comb begin
      stall_if_id  = (hazard | mem_busy) & ~flush;
      ex_valid     = ctrl_q.valid;
      ex_wb        = ctrl_q.wb;
      ex_mem_read  = ctrl_q.mem_read;
      ex_mem_write = ctrl_q.mem_write;
      ex_src       = src_q;
      ex_dst       = dst_q;
      ex_alu_op    = op_q;
      ex_op1       = op1_q;
      ex_op2       = op2_q;
      stall_count  = cnt_q;
   end

endmodule

// File: tb/tb_id_ex_stage_register.sv
// Randomized bench for id_ex_stage_register against
// a behavioural model; second instance checks saturation.
module tb_id_ex_stage_register;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        id_valid = 0, id_uses_src = 0, id_uses_dst = 0;
   logic        id_wb = 0, id_mem_read = 0, id_mem_write = 0;
   logic [2:0]  id_src = 0, id_dst = 0;
   logic [3:0]  id_alu_op = 0;
   logic [15:0] id_op1 = 0, id_op2 = 0;
   logic        mem_busy = 0, flush = 0;

   logic        ex_valid, ex_wb, ex_mem_read, ex_mem_write;
   logic [2:0]  ex_src, ex_dst;
   logic [3:0]  ex_alu_op;
   logic [15:0] ex_op1, ex_op2;
   logic        stall_if_id;
   logic [15:0] stall_count;

   logic        v2, wb2, mr2, mw2, st2;
   logic [2:0]  src2, dst2;
   logic [3:0]  aop2;
   logic [15:0] o1_2, o2_2;
   logic [1:0]  cnt2;

   always #5 clk = ~clk;

   id_ex_stage_register dut (
      .clk(clk), .rst(rst), .id_valid(id_valid),
      .id_src(id_src), .id_dst(id_dst),
      .id_uses_src(id_uses_src), .id_uses_dst(id_uses_dst),
      .id_wb(id_wb), .id_mem_read(id_mem_read),
      .id_mem_write(id_mem_write), .id_alu_op(id_alu_op),
      .id_op1(id_op1), .id_op2(id_op2),
      .mem_busy(mem_busy), .flush(flush),
      .ex_valid(ex_valid), .ex_wb(ex_wb),
      .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
      .ex_src(ex_src), .ex_dst(ex_dst), .ex_alu_op(ex_alu_op),
      .ex_op1(ex_op1), .ex_op2(ex_op2),
      .stall_if_id(stall_if_id), .stall_count(stall_count)
   );

   id_ex_stage_register #(.CNT_W(2)) dut_sat (
      .clk(clk), .rst(rst), .id_valid(id_valid),
      .id_src(id_src), .id_dst(id_dst),
      .id_uses_src(id_uses_src), .id_uses_dst(id_uses_dst),
      .id_wb(id_wb), .id_mem_read(id_mem_read),
      .id_mem_write(id_mem_write), .id_alu_op(id_alu_op),
      .id_op1(id_op1), .id_op2(id_op2),
      .mem_busy(mem_busy), .flush(flush),
      .ex_valid(v2), .ex_wb(wb2),
      .ex_mem_read(mr2), .ex_mem_write(mw2),
      .ex_src(src2), .ex_dst(dst2), .ex_alu_op(aop2),
      .ex_op1(o1_2), .ex_op2(o2_2),
      .stall_if_id(st2), .stall_count(cnt2)
   );

   int n_cmp = 0;
   int n_err = 0;

   logic        m_valid, m_wb, m_mr, m_mw;
   logic [2:0]  m_src, m_dst;
   logic [3:0]  m_op;
   logic [15:0] m_op1, m_op2;
   int          m_cnt, m_cnt2;

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // A load in EX stalls any real consumer that reads its target register.
   function automatic bit m_hazard();
      bit ld_in_ex;
      bit reads;
      ld_in_ex = m_valid && m_mr && m_wb;
      reads = (id_uses_src && id_src == m_dst)
           || (id_uses_dst && id_dst == m_dst);
      return ld_in_ex && id_valid && reads;
   endfunction

   task automatic m_bubble();
      {m_valid, m_wb, m_mr, m_mw} = 4'b0;
      m_src = 0; m_dst = 0; m_op = 0; m_op1 = 0; m_op2 = 0;
   endtask

   task automatic m_reset();
      m_bubble();
      m_cnt = 0;
      m_cnt2 = 0;
   endtask

   task automatic m_edge();
      bit h;
      h = m_hazard();
      if (flush) m_bubble();
      else if (mem_busy) begin end
      else if (h) begin
         m_bubble();
         m_cnt  = (m_cnt  < 65535) ? m_cnt + 1  : m_cnt;
         m_cnt2 = (m_cnt2 < 3)     ? m_cnt2 + 1 : m_cnt2;
      end else begin
         m_valid = id_valid;
         m_wb  = id_valid && id_wb;
         m_mr  = id_valid && id_mem_read;
         m_mw  = id_valid && id_mem_write;
         m_src = id_src; m_dst = id_dst; m_op = id_alu_op;
         m_op1 = id_op1; m_op2 = id_op2;
      end
   endtask

   task automatic check_all();
      chk("ex_valid", ex_valid, m_valid);
      chk("ex_wb", ex_wb, m_wb);
      chk("ex_mem_read", ex_mem_read, m_mr);
      chk("ex_mem_write", ex_mem_write, m_mw);
      chk("ex_src", ex_src, m_src);
      chk("ex_dst", ex_dst, m_dst);
      chk("ex_alu_op", ex_alu_op, m_op);
      chk("ex_op1", ex_op1, m_op1);
      chk("ex_op2", ex_op2, m_op2);
      chk("stall_count", stall_count, m_cnt);
      chk("stall_count_sat", cnt2, m_cnt2);
   endtask

   // Entered and left at posedge+1; inputs stay put across the edge.
   task automatic cycle();
      #3;
      chk("stall_if_id", stall_if_id,
          (m_hazard() || mem_busy) && !flush);
      @(posedge clk);
      m_edge();
      #1;
      check_all();
   endtask

   task automatic set_instr(bit v, bit ld, bit st, bit wb,
                            logic [2:0] s, bit us,
                            logic [2:0] d, bit ud,
                            logic [15:0] a, logic [15:0] b);
      id_valid = v; id_mem_read = ld; id_mem_write = st;
      id_wb = wb; id_src = s; id_uses_src = us;
      id_dst = d; id_uses_dst = ud;
      id_alu_op = 4'(($urandom % 8));
      id_op1 = a; id_op2 = b;
      mem_busy = 0; flush = 0;
   endtask

   task automatic rand_inputs();
      id_valid     = ($urandom % 8) != 0;
      id_mem_read  = ($urandom % 2) == 0;
      id_mem_write = ($urandom % 4) == 0;
      id_wb        = ($urandom % 4) != 0;
      id_uses_src  = ($urandom % 4) != 0;
      id_uses_dst  = ($urandom % 3) == 0;
      id_src = ($urandom % 2) ? m_dst : 3'($urandom % 8);
      id_dst = ($urandom % 3 == 0) ? m_dst : 3'($urandom % 8);
      id_alu_op = 4'($urandom % 16);
      id_op1 = 16'($urandom);
      id_op2 = 16'($urandom);
      mem_busy = ($urandom % 7) == 0;
      flush    = ($urandom % 9) == 0;
   endtask

   initial begin
      m_reset();
      @(posedge clk);
      #1;
      check_all();
      rst = 1'b0;

      // load r3 then a consumer of r3: one bubble, then capture
      set_instr(1, 1, 0, 1, 3'd1, 0, 3'd3, 0, 16'h1111, 16'h2222);
      cycle();
      set_instr(1, 0, 0, 1, 3'd3, 1, 3'd5, 1, 16'h0A0A, 16'h0505);
      cycle();
      chk("ld_use_bubble", ex_valid, 1'b0);
      chk("ld_use_count", stall_count, 1);
      cycle();
      chk("ld_use_src", ex_src, 3'd3);

      // load r3, consumer uses r2/r4: no stall
      set_instr(1, 1, 0, 1, 3'd0, 0, 3'd3, 0, 16'h0, 16'h0);
      cycle();
      set_instr(1, 0, 0, 1, 3'd2, 1, 3'd4, 1, 16'h1234, 16'h5678);
      cycle();
      chk("no_haz_valid", ex_valid, 1'b1);

      // hold for three memory-stall cycles
      set_instr(1, 0, 0, 1, 3'd6, 1, 3'd7, 1, 16'hBEEF, 16'hCAFE);
      cycle();
      mem_busy = 1;
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("busy_hold_op1", ex_op1, 16'hBEEF);
      end

      // flush during a hazard
      set_instr(1, 1, 0, 1, 3'd0, 0, 3'd2, 0, 16'h0, 16'h0);
      cycle();
      set_instr(1, 0, 0, 1, 3'd2, 1, 3'd1, 0, 16'h7777, 16'h8888);
      flush = 1;
      cycle();
      chk("flush_bubble", ex_valid, 1'b0);

      // repeated load-use pairs drive the 2-bit counter to saturation
      for (int i = 0; i < 5; i++) begin
         set_instr(1, 1, 0, 1, 3'd0, 0, 3'd4, 0, 16'h0, 16'h0);
         cycle();
         set_instr(1, 0, 0, 1, 3'd4, 1, 3'd0, 0, 16'h1, 16'h2);
         cycle();
      end
      chk("sat_count", cnt2, 2'd3);

      for (int i = 0; i < 3000; i++) begin
         rand_inputs();
         cycle();
      end

      // reset asserted mid-stall
      set_instr(1, 1, 0, 1, 3'd0, 0, 3'd5, 0, 16'h0, 16'h0);
      cycle();
      set_instr(1, 0, 0, 1, 3'd5, 1, 3'd1, 0, 16'h3, 16'h4);
      #3;
      chk("pre_rst_stall", stall_if_id, 1'b1);
      rst = 1'b1;
      #1;
      m_reset();
      chk("rst_stall", stall_if_id, 1'b0);
      check_all();
      @(posedge clk);
      #2;
      rst = 1'b0;
      @(posedge clk);
      #1;
      m_edge();
      check_all();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
